// File: rtl/vram_fill_if.sv
// Bundles the host write port, fill control inputs and the merged VRAM write port.
// The engine's side is the slave; the host/controller side is the master.
interface vram_fill_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] hostWrAddr;
    logic [DATA_W-1:0] hostWrData;
    logic              hostWr;
    logic              fillStart;
    logic              fillAbort;
    logic [ADDR_W-1:0] fillAddr;
    logic [ADDR_W-1:0] fillLen;
    logic [DATA_W-1:0] fillChar;
    logic [DATA_W-1:0] fillAttr;
    logic [ADDR_W-1:0] vramWrAddr;
    logic [DATA_W-1:0] vramWrData;
    logic              vramWr;
    logic              fillBusy;
    logic              fillDone;

    modport master (
        output hostWrAddr, hostWrData, hostWr,
        output fillStart, fillAbort, fillAddr, fillLen, fillChar, fillAttr,
        input  vramWrAddr, vramWrData, vramWr, fillBusy, fillDone
    );

    modport slave (
        input  hostWrAddr, hostWrData, hostWr,
        input  fillStart, fillAbort, fillAddr, fillLen, fillChar, fillAttr,
        output vramWrAddr, vramWrData, vramWr, fillBusy, fillDone
    );
endinterface

// File: rtl/vram_fill.sv
// VRAM write merger: host writes pass straight through, and a char/attr block fill
// uses every cycle the host leaves free.
module vram_fill #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        nrst,
    vram_fill_if.slave  bus
);
    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_cur, w_cur;
    logic [ADDR_W-1:0] r_rem, w_rem;
    logic [DATA_W-1:0] r_char, w_char;
    logic [DATA_W-1:0] r_attr, w_attr;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_W-1:0] r_wr_data, w_wr_data;
    logic              r_wr, w_wr;
    logic              r_busy, w_busy;
    logic              r_done, w_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_rem     <= '0;
            r_char    <= '0;
            r_attr    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cur     <= w_cur;
            r_rem     <= w_rem;
            r_char    <= w_char;
            r_attr    <= w_attr;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_wr      <= w_wr;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cur     = r_cur;
        w_rem     = r_rem;
        w_char    = r_char;
        w_attr    = r_attr;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_wr      = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;

        // Host path is unconditional; the fill only claims the port when this is idle.
        if (bus.hostWr) begin
            w_wr      = 1'b1;
            w_wr_addr = bus.hostWrAddr;
            w_wr_data = bus.hostWrData;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.fillStart && !bus.fillAbort) begin
                    w_cur  = bus.fillAddr;
                    w_rem  = bus.fillLen;
                    w_char = bus.fillChar;
                    w_attr = bus.fillAttr;
                    if (bus.fillLen != '0) begin
                        w_state = S_FILL;
                        w_busy  = 1'b1;
                    end else begin
                        w_done  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                w_busy = 1'b1;
                if (bus.fillAbort) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                end else if (!bus.hostWr) begin
                    w_wr      = 1'b1;
                    w_wr_addr = r_cur;
                    w_wr_data = r_cur[0] ? r_attr : r_char;
                    w_cur     = r_cur + ONE;
                    w_rem     = r_rem - ONE;
                    if (r_rem == ONE) begin
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.vramWrAddr = r_wr_addr;
    assign bus.vramWrData = r_wr_data;
    assign bus.vramWr     = r_wr;
    assign bus.fillBusy   = r_busy;
    assign bus.fillDone   = r_done;
endmodule

// File: tb/tb_vram_fill.sv
// Scoreboard bench for vram_fill: stimulus pushes the expected VRAM port events,
// a negedge monitor pops and compares every write / done pulse.
module tb_vram_fill;
    typedef struct packed {
        logic        wr;
        logic [12:0] addr;
        logic [7:0]  data;
        logic        done;
    } ev_t;

    logic clk = 1'b0;
    logic nrst;
    ev_t  q[$];
    logic exp_busy = 1'b0;
    logic end_req  = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    vram_fill_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    vram_fill #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input logic wr, input logic [12:0] a, input logic [7:0] d,
                               input logic done);
        ev_t e;
        e.wr = wr; e.addr = a; e.data = d; e.done = done;
        return e;
    endfunction

    // Monitor: owns every comparison and both counters.
    always @(negedge clk) begin
        ev_t e;
        if (!nrst) begin
            checks++;
            if (bus.vramWr !== 1'b0 || bus.fillBusy !== 1'b0 || bus.fillDone !== 1'b0 ||
                bus.vramWrAddr !== 13'h0 || bus.vramWrData !== 8'h0) begin
                errors++;
                $display("FAIL reset_outputs got wr=%b busy=%b done=%b addr=%h data=%h want all 0",
                         bus.vramWr, bus.fillBusy, bus.fillDone, bus.vramWrAddr, bus.vramWrData);
            end
        end else begin
            checks++;
            if (bus.fillBusy !== exp_busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, bus.fillBusy, exp_busy);
            end
            if (bus.vramWr || bus.fillDone) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event t=%0t got wr=%b addr=%h data=%h done=%b want none",
                             $time, bus.vramWr, bus.vramWrAddr, bus.vramWrData, bus.fillDone);
                end else begin
                    e = q.pop_front();
                    if (bus.vramWr !== e.wr || bus.fillDone !== e.done ||
                        (e.wr && (bus.vramWrAddr !== e.addr || bus.vramWrData !== e.data))) begin
                        errors++;
                        $display("FAIL port_event t=%0t got wr=%b addr=%h data=%h done=%b want wr=%b addr=%h data=%h done=%b",
                                 $time, bus.vramWr, bus.vramWrAddr, bus.vramWrData, bus.fillDone,
                                 e.wr, e.addr, e.data, e.done);
                    end
                end
            end
        end
        if (end_req) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL missing_events got %0d pending want 0", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want end of stimulus");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [12:0] a, input logic [7:0] d);
        bus.hostWr = 1'b1; bus.hostWrAddr = a; bus.hostWrData = d;
        q.push_back(mk(1'b1, a, d, 1'b0));
        step();
        bus.hostWr = 1'b0;
    endtask

    // Reference: fill write k goes to (fa+k) mod 8192, char on even / attr on odd
    // addresses; a host write in a FILL cycle takes the port and defers the fill.
    // hmode: 0 no host, 1 random host writes, 2 host 0x0800/0xEE in the second cycle.
    task automatic do_fill(input logic [12:0] fa, input int len, input logic [7:0] ch,
                           input logic [7:0] at, input int hmode, input int abort_at,
                           input int rst_at);
        int k = 0;
        int c = 0;
        bit h;
        logic [12:0] a;
        bus.fillStart = 1'b1; bus.fillAbort = 1'b0; bus.hostWr = 1'b0;
        bus.fillAddr = fa; bus.fillLen = 13'(len); bus.fillChar = ch; bus.fillAttr = at;
        if (len == 0) q.push_back(mk(1'b0, 13'h0, 8'h0, 1'b1));
        step();
        bus.fillStart = 1'b0;
        exp_busy = (len != 0);
        while (k < len) begin
            if (c == rst_at) begin
                #2 nrst = 1'b0;
                q.delete();
                exp_busy = 1'b0;
                bus.fillStart = 1'b0; bus.hostWr = 1'b0;
                repeat (3) step();
                nrst = 1'b1;
                repeat (4) step();
                return;
            end
            // Inputs that must be ignored while filling.
            bus.fillAddr  = 13'($urandom);
            bus.fillLen   = 13'($urandom);
            bus.fillChar  = 8'($urandom);
            bus.fillAttr  = 8'($urandom);
            bus.fillStart = 1'($urandom);
            h = (hmode == 1) ? ($urandom_range(0, 3) == 0) : (hmode == 2 && c == 1);
            if (h) begin
                bus.hostWr = 1'b1;
                bus.hostWrAddr = (hmode == 2) ? 13'h0800 : 13'($urandom);
                bus.hostWrData = (hmode == 2) ? 8'hEE : 8'($urandom);
                q.push_back(mk(1'b1, bus.hostWrAddr, bus.hostWrData, 1'b0));
            end else begin
                bus.hostWr = 1'b0;
            end
            if (c == abort_at) begin
                bus.fillAbort = 1'b1;
                step();
                bus.fillAbort = 1'b0; bus.hostWr = 1'b0; bus.fillStart = 1'b0;
                exp_busy = 1'b0;
                return;
            end
            if (!h) begin
                a = fa + 13'(k);
                q.push_back(mk(1'b1, a, a[0] ? at : ch, k == len - 1));
                k++;
            end
            c++;
            step();
            if (k == len) exp_busy = 1'b0;
        end
        bus.hostWr = 1'b0; bus.fillStart = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        bus.hostWr = 1'b0; bus.hostWrAddr = '0; bus.hostWrData = '0;
        bus.fillStart = 1'b0; bus.fillAbort = 1'b0; bus.fillAddr = '0;
        bus.fillLen = '0; bus.fillChar = '0; bus.fillAttr = '0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        step();

        host_wr(13'h0123, 8'hAB);
        host_wr(13'h1FFF, 8'h55);
        repeat (2) step();

        // Start with abort in IDLE must be ignored.
        bus.fillStart = 1'b1; bus.fillAbort = 1'b1; bus.fillLen = 13'd5;
        step();
        bus.fillStart = 1'b0; bus.fillAbort = 1'b0;
        repeat (2) step();

        do_fill(13'h0010, 4, 8'h20, 8'h07, 0, -1, -1);
        step();
        do_fill(13'h0000, 4, 8'h20, 8'h07, 2, -1, -1);
        step();
        do_fill(13'h1FFE, 4, 8'h41, 8'h1F, 0, -1, -1);
        step();
        do_fill(13'h0300, 0, 8'h11, 8'h22, 0, -1, -1);
        step();

        // Back-to-back: each fill starts in the cycle the previous fillDone is high.
        do_fill(13'h0400, 3, 8'hA1, 8'hB2, 0, -1, -1);
        do_fill(13'h0401, 2, 8'hC3, 8'hD4, 1, -1, -1);
        do_fill(13'h0500, 0, 8'h00, 8'h00, 0, -1, -1);
        step();

        do_fill(13'h0100, 100, 8'h20, 8'h07, 0, 2, -1);
        repeat (3) step();

        for (int i = 0; i < 10; i++) begin
            do_fill(13'($urandom), int'($urandom_range(0, 40)), 8'($urandom), 8'($urandom),
                    1, -1, -1);
            repeat ($urandom_range(0, 2)) step();
        end
        do_fill(13'($urandom), 60, 8'($urandom), 8'($urandom), 1,
                int'($urandom_range(3, 30)), -1);
        repeat (2) step();

        do_fill(13'h0200, 100, 8'h20, 8'h07, 0, -1, 5);
        repeat (3) step();
        end_req = 1'b1;
    end
endmodule
